eq_gain_ctrl: RTL and testbench



---
 rtl/eq_pkg.sv | 35 +++
 rtl/eq_gain_ctrl_if.sv | 27 ++
 rtl/eq_gain_lane.sv | 53 +++++
 rtl/eq_gain_ctrl.sv | 108 ++++++++++
 tb/tb_eq_gain_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer gain controller and its lanes.
package eq_pkg;

    localparam int NUM_BANDS  = 8;
    localparam int GAIN_W     = 8;
    localparam int GAIN_UNITY = 1;

    // One spare bit beyond what NUM_BANDS needs, so out-of-range indices
    // (8..15) reach the controller and can be flagged instead of aliasing.
    localparam int BAND_W     = $clog2(NUM_BANDS) + 1;

    typedef logic signed [GAIN_W-1:0] gain_t;
    typedef logic [BAND_W-1:0]        band_idx_t;
    typedef gain_t [NUM_BANDS-1:0]    gain_vec_t;

    localparam band_idx_t BAND_LIMIT = band_idx_t'(NUM_BANDS);

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } wr_state_t;

    // Move one LSB toward the target; never overshoots, so no saturation needed.
    function automatic gain_t step_toward(input gain_t cur, input gain_t tgt);
        gain_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + gain_t'(1);
        end else if (cur > tgt) begin
            res = cur - gain_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/eq_gain_ctrl_if.sv
// Gain write port: valid/ready handshake carrying band, gain and snap flag.
interface eq_gain_ctrl_if;
    import eq_pkg::*;

    logic      wr_valid;
    logic      wr_ready;
    band_idx_t wr_band;
    gain_t     wr_gain;
    logic      wr_snap;

    modport master (
        output wr_valid,
        output wr_band,
        output wr_gain,
        output wr_snap,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_band,
        input  wr_gain,
        input  wr_snap,
        output wr_ready
    );

endinterface

// File: rtl/eq_gain_lane.sv
// One equalizer band: target and applied gain, +/-1 ramp step, snap load,
// plus registered "still ramping" and "applied gain just changed" flags.
module eq_gain_lane
    import eq_pkg::*;
#(
    parameter gain_t GAIN_RESET = gain_t'(GAIN_UNITY)
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  step,
    input  logic  wr_en,
    input  logic  snap,
    input  gain_t wr_gain,
    output gain_t cur,
    output logic  ramping,
    output logic  changed
);

    gain_t tgt;
    gain_t tgt_next;
    gain_t cur_next;

    // Next-state: a commit retargets; a snap overrides any coincident step,
    // and a step always chases the target as it was before this cycle's commit.
    always_comb begin
        tgt_next = tgt;
        cur_next = cur;
        if (wr_en) begin
            tgt_next = wr_gain;
        end
        if (wr_en && snap) begin
            cur_next = wr_gain;
        end else if (step) begin
            cur_next = step_toward(cur, tgt);
        end
    end

    // Gain registers and the flags derived from their next values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt     <= GAIN_RESET;
            cur     <= GAIN_RESET;
            ramping <= 1'b0;
            changed <= 1'b0;
        end else begin
            tgt     <= tgt_next;
            cur     <= cur_next;
            ramping <= (cur_next != tgt_next);
            changed <= (cur_next != cur);
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Gain configuration and ramp controller for the 8-band equalizer.
// Writes land in a one-entry buffer and commit on the following cycle;
// applied gains step toward their targets only on ramp-step sample ticks.
module eq_gain_ctrl
    import eq_pkg::*;
#(
    parameter int    RAMP_DIV   = 1,
    parameter gain_t GAIN_RESET = gain_t'(GAIN_UNITY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_tick,
    eq_gain_ctrl_if.slave wr,
    output gain_vec_t     g,
    output logic          g_update,
    output logic          busy,
    output logic          wr_err
);

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    wr_state_t  state;
    logic       ready_q;
    band_idx_t  pend_band;
    gain_t      pend_gain;
    logic       pend_snap;

    logic [7:0] div;
    logic       step;
    logic       commit;
    logic       commit_ok;

    logic [NUM_BANDS-1:0] lane_ramping;
    logic [NUM_BANDS-1:0] lane_changed;

    assign wr.wr_ready = ready_q;
    assign commit      = (state == ST_COMMIT);
    assign commit_ok   = commit && (pend_band < BAND_LIMIT);
    assign step        = sample_tick && (div == DIV_LAST);

    // Write FSM: accept into the buffer in IDLE, apply it in COMMIT; ready is
    // held low through reset and raised on the first clock after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b0;
            pend_band <= '0;
            pend_gain <= '0;
            pend_snap <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_err <= 1'b0;
                    if (ready_q && wr.wr_valid) begin
                        pend_band <= wr.wr_band;
                        pend_gain <= wr.wr_gain;
                        pend_snap <= wr.wr_snap;
                        wr_err    <= (wr.wr_band >= BAND_LIMIT);
                        ready_q   <= 1'b0;
                        state     <= ST_COMMIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    wr_err  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    wr_err  <= 1'b0;
                    ready_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Ramp divider: counts sample ticks and wraps on the tick that steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
        end else if (sample_tick) begin
            div <= step ? 8'd0 : div + 8'd1;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_lane
        eq_gain_lane #(
            .GAIN_RESET (GAIN_RESET)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .step    (step),
            .wr_en   (commit_ok && (pend_band == band_idx_t'(b))),
            .snap    (pend_snap),
            .wr_gain (pend_gain),
            .cur     (g[b]),
            .ramping (lane_ramping[b]),
            .changed (lane_changed[b])
        );
    end

    assign busy     = commit || (|lane_ramping);
    assign g_update = |lane_changed;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl: two instances (ramp divider 1 and 4),
// expected g vectors queued at stimulus time and popped on each g_update.
module tb_eq_gain_ctrl;
    import eq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic tick_a;
    logic tick_b;

    gain_vec_t g_a, g_b;
    logic upd_a, upd_b, busy_a, busy_b, err_a, err_b;

    eq_gain_ctrl_if wa ();
    eq_gain_ctrl_if wb ();

    int n_compared   = 0;
    int n_mismatched = 0;
    int err_seen_a   = 0;
    int err_seen_b   = 0;

    gain_vec_t exp_q_a[$];
    gain_vec_t exp_q_b[$];
    gain_vec_t head_a, head_b;
    gain_vec_t base;

    always #5 clk = ~clk;

    eq_gain_ctrl #(.RAMP_DIV(1), .GAIN_RESET(gain_t'(1))) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (tick_a),
        .wr          (wa),
        .g           (g_a),
        .g_update    (upd_a),
        .busy        (busy_a),
        .wr_err      (err_a)
    );

    eq_gain_ctrl #(.RAMP_DIV(4), .GAIN_RESET(gain_t'(1))) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (tick_b),
        .wr          (wb),
        .g           (g_b),
        .g_update    (upd_b),
        .busy        (busy_b),
        .wr_err      (err_b)
    );

    function automatic gain_vec_t unity_vec();
        gain_vec_t r;
        for (int i = 0; i < NUM_BANDS; i++) r[i] = gain_t'(1);
        return r;
    endfunction

    function automatic gain_vec_t vec_with(input gain_vec_t v, input int b, input int val);
        gain_vec_t r;
        r = v;
        r[b] = gain_t'(val);
        return r;
    endfunction

    function automatic int gval(input gain_vec_t v, input int b);
        gain_t t;
        t = v[b];
        return int'(t);
    endfunction

    function automatic logic ready_of(input bit sel);
        return sel ? wb.wr_ready : wa.wr_ready;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_vec(input string name, input gain_vec_t actual, input gain_vec_t expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive_wr(input bit sel, input logic valid, input int band, input int gain, input logic snap);
        if (sel) begin
            wb.wr_valid = valid;
            wb.wr_band  = band_idx_t'(band);
            wb.wr_gain  = gain_t'(gain);
            wb.wr_snap  = snap;
        end else begin
            wa.wr_valid = valid;
            wa.wr_band  = band_idx_t'(band);
            wa.wr_gain  = gain_t'(gain);
            wa.wr_snap  = snap;
        end
    endtask

    task automatic set_tick(input bit sel, input logic v);
        if (sel) tick_b = v;
        else     tick_a = v;
    endtask

    // One write; returns one clock after the commit edge. Optionally holds
    // sample_tick high so the ramp step lands on the commit edge.
    task automatic applyStimulus(input bit sel, input int band, input int gain,
                                 input logic snap, input bit tick_on_commit);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        drive_wr(sel, 1'b1, band, gain, snap);
        @(negedge clk);
        while (ready_of(sel) !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL wr_ready_timeout: got ready=%b, expected 1 within 20 cycles", ready_of(sel));
        end
        @(posedge clk); #1;
        drive_wr(sel, 1'b0, 0, 0, 1'b0);
        if (tick_on_commit) set_tick(sel, 1'b1);
        @(posedge clk); #1;
        set_tick(sel, 1'b0);
    endtask

    // One sample tick; returns at the negedge after the edge that sampled it.
    task automatic tick_once(input bit sel);
        @(posedge clk); #1;
        set_tick(sel, 1'b1);
        @(posedge clk); #1;
        set_tick(sel, 1'b0);
        @(negedge clk);
    endtask

    // Monitor: every g_update must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (upd_a === 1'b1) begin
                n_compared++;
                if (exp_q_a.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_update_a: got g=%h, expected no g_update", g_a);
                end else begin
                    head_a = exp_q_a.pop_front();
                    if (g_a !== head_a) begin
                        n_mismatched++;
                        $display("[TB] FAIL update_a: got g=%h, expected %h", g_a, head_a);
                    end
                end
            end
            if (upd_b === 1'b1) begin
                n_compared++;
                if (exp_q_b.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_update_b: got g=%h, expected no g_update", g_b);
                end else begin
                    head_b = exp_q_b.pop_front();
                    if (g_b !== head_b) begin
                        n_mismatched++;
                        $display("[TB] FAIL update_b: got g=%h, expected %h", g_b, head_b);
                    end
                end
            end
            if (err_a === 1'b1) err_seen_a++;
            if (err_b === 1'b1) err_seen_b++;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        int bands[3];
        int gains[3];
        bands = '{1, 1, 9};
        gains = '{7, -3, 50};

        rst_n  = 1'b0;
        tick_a = 1'b0;
        tick_b = 1'b0;
        drive_wr(1'b0, 1'b0, 0, 0, 1'b0);
        drive_wr(1'b1, 1'b0, 0, 0, 1'b0);

        // Reset held for three edges, then released
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready_a", int'(wa.wr_ready), 0);
        checkOutput("reset_ready_b", int'(wb.wr_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_ready_a", int'(wa.wr_ready), 1);
        checkOutput("post_reset_ready_b", int'(wb.wr_ready), 1);
        checkOutput("post_reset_busy_a", int'(busy_a), 0);
        checkOutput("post_reset_update_a", int'(upd_a), 0);
        checkOutput("post_reset_err_a", int'(err_a), 0);
        check_vec("post_reset_g_a", g_a, unity_vec());
        check_vec("post_reset_g_b", g_b, unity_vec());

        // Ramp up band 3 to 5 with a step every tick
        applyStimulus(1'b0, 3, 5, 1'b0, 1'b0);
        checkOutput("ramp_up_busy_start", int'(busy_a), 1);
        for (int k = 2; k <= 5; k++) exp_q_a.push_back(vec_with(unity_vec(), 3, k));
        for (int t = 1; t <= 6; t++) begin
            tick_once(1'b0);
            checkOutput("ramp_up_g3", gval(g_a, 3), (t < 4) ? 1 + t : 5);
            checkOutput("ramp_up_busy", int'(busy_a), (t < 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        checkOutput("ramp_up_pending", exp_q_a.size(), 0);

        // Ramp band 0 down to -2 with a step every fourth tick
        applyStimulus(1'b1, 0, -2, 1'b0, 1'b0);
        for (int k = 0; k >= -2; k--) exp_q_b.push_back(vec_with(unity_vec(), 0, k));
        for (int t = 1; t <= 12; t++) begin
            tick_once(1'b1);
            checkOutput("ramp_down_g0", gval(g_b, 0), 1 - t / 4);
        end
        checkOutput("ramp_down_busy_end", int'(busy_b), 0);
        @(posedge clk); #1;
        checkOutput("ramp_down_pending", exp_q_b.size(), 0);

        // Snap band 7 to -100 with a step landing on the commit edge
        base = vec_with(unity_vec(), 3, 5);
        base = vec_with(base, 7, -100);
        exp_q_a.push_back(base);
        applyStimulus(1'b0, 7, -100, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("snap_g7", gval(g_a, 7), -100);
        checkOutput("snap_update", int'(upd_a), 1);
        checkOutput("snap_busy", int'(busy_a), 0);
        @(negedge clk);
        checkOutput("snap_update_once", int'(upd_a), 0);
        @(posedge clk); #1;
        checkOutput("snap_pending", exp_q_a.size(), 0);

        // Retarget band 2 mid-ramp: 1 -> 10, reaches 4, then retarget to 0
        applyStimulus(1'b0, 2, 10, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) exp_q_a.push_back(vec_with(base, 2, k));
        for (int t = 1; t <= 3; t++) begin
            tick_once(1'b0);
            checkOutput("retarget_up_g2", gval(g_a, 2), 1 + t);
        end
        applyStimulus(1'b0, 2, 0, 1'b0, 1'b0);
        checkOutput("retarget_busy_start", int'(busy_a), 1);
        for (int k = 3; k >= 0; k--) exp_q_a.push_back(vec_with(base, 2, k));
        for (int t = 1; t <= 4; t++) begin
            tick_once(1'b0);
            checkOutput("retarget_down_g2", gval(g_a, 2), 4 - t);
            checkOutput("retarget_busy", int'(busy_a), (t < 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        checkOutput("retarget_pending", exp_q_a.size(), 0);
        base = vec_with(base, 2, 0);

        // Back-to-back writes with wr_valid held: band 1 twice, then bad band 9
        @(posedge clk); #1;
        wa.wr_valid = 1'b1;
        wa.wr_snap  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wa.wr_band = band_idx_t'(bands[i]);
            wa.wr_gain = gain_t'(gains[i]);
            @(negedge clk);
            checkOutput("b2b_ready_idle", int'(wa.wr_ready), 1);
            @(posedge clk); #1;
            if (i == 2) wa.wr_valid = 1'b0;
            @(negedge clk);
            checkOutput("b2b_ready_commit", int'(wa.wr_ready), 0);
            checkOutput("b2b_wr_err", int'(err_a), (i == 2) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("b2b_busy", int'(busy_a), 1);
        for (int k = 0; k >= -3; k--) exp_q_a.push_back(vec_with(base, 1, k));
        for (int t = 1; t <= 5; t++) begin
            tick_once(1'b0);
            checkOutput("b2b_g1", gval(g_a, 1), (t < 4) ? 1 - t : -3);
            checkOutput("b2b_busy_ramp", int'(busy_a), (t < 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        checkOutput("b2b_pending", exp_q_a.size(), 0);
        checkOutput("wr_err_count_a", err_seen_a, 1);
        checkOutput("wr_err_count_b", err_seen_b, 0);
        checkOutput("final_pending_b", exp_q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
